uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter; the transmit counterpart of UART_RX in the APB UART IP.
- Accepts a parallel word from the APB register bank through a start/busy handshake.
- Serialises the word LSB-first as start bit, DATA_BITS data bits, an optional parity bit and STOP_BITS stop bits.
- Line idles high. Bit timing comes from an integer clocks-per-bit divider on PCLK.

Parameters:
- BAUD_RATE, 9600: line bit rate in bits/s.
- CLK_FREQ, 100_000_000: PCLK frequency in Hz.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- STOP_BITS, 1: stop bits per frame; 1 or 2.

Ports:
- PCLK  input  1  system clock.
- PRESET  input  1  asynchronous active-high reset.
- tx_data  input  DATA_BITS  word to transmit; sampled only on an accepted tx_start.
- tx_start  input  1  request to send; accepted when tx_busy=0.
- tx_serial  output  1  serial line, idle high.
- tx_busy  output  1  frame in progress; new requests are ignored while high.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-high.
- Divider: CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, truncating integer division. Default value is 10416.
  - Bit counter width is clog2(CLKS_PER_BIT).
  - Data index width is clog2(DATA_BITS).
- Reset (asynchronous, PRESET=1):
  - State = IDLE; tx_serial=1; tx_busy=0; tx_done=0.
  - Shift register, baud counter and bit index are cleared.
  - Reset asserted mid-frame aborts the frame immediately. The line returns high with no glitch low.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - tx_start=1 at a rising edge latches tx_data into the shift register and moves the FSM to START.
  - tx_busy=1 and tx_serial=0 from the next cycle (latency 1 cycle).
- START: drive 0 for CLKS_PER_BIT cycles, then go to DATA with bit index = 0.
- DATA:
  - Drive shift register bit 0 for CLKS_PER_BIT cycles, then shift right.
  - After bit DATA_BITS-1, go to PARITY (macro defined) or STOP.
- STOP:
  - Drive 1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
  - tx_done=1 and tx_busy=0 in that same registered cycle.
- Output registering: all outputs are registered. tx_serial comes straight from a flop, so the line is glitch-free.
- Frame length: exactly (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles of tx_busy=1, where P = 1 with parity and 0 without.
- Back-to-back frames: tx_start held high, or asserted in the cycle tx_done=1, is accepted because tx_busy=0 in that cycle.
  - The next start bit follows the previous stop bit after exactly 1 idle-high cycle.
- tx_start while tx_busy=1: ignored. tx_data changes during a frame have no effect.
- tx_start asserted coincident with reset deassertion: ignored in that cycle; FSM stays in IDLE.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA, lasting one bit period.
  - An extra parameter PARITY_ODD (default 0) selects the parity: even parity = XOR of the data bits; odd parity = the inverse of that.
  - Parity is computed from the latched word at acceptance time.
- Undefined: no PARITY state, no PARITY_ODD parameter, and the frame length omits the parity bit.

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE/START/DATA/PARITY/STOP).
  - Function computing CLKS_PER_BIT.
  - clog2 helper.
  - Line idle level constant (1).
  - UART_RX reuses the package.
- One sub-module, uart_baud_tick:
  - Loadable down-counter producing a one-cycle bit-end tick every CLKS_PER_BIT cycles.
  - Reloads on a restart input.
  - Shared with UART_RX (mid-bit sampling uses a half-period load).

Test Plan:
- Reset: hold PRESET=1 for 100 ns, then release -> tx_serial=1, tx_busy=0, tx_done=0; no transitions for 20 bit periods.
- Single frame 8'h0F at default parameters:
  - Line sequence 0,1,1,1,1,0,0,0,0,1.
  - Each bit lasts 10416 cycles; tx_busy high for 104160 cycles.
  - tx_done pulses once.
- Loopback: tx_serial into UART_RX; send 8'h0F, 8'hEE, 8'hCD back-to-back with tx_start held high -> rx_data sequence 0F, EE, CD; frame_error=0; exactly 1 idle cycle between frames.
- Busy rejection: pulse tx_start with 8'hAA mid-frame of 8'h55 -> only 8'h55 transmitted; no second frame.
- Reset mid-frame: assert PRESET during bit 3 of 8'hCD -> tx_serial=1 asynchronously; tx_busy=0; the next tx_start produces a clean full frame.
- UART_TX_PARITY_EN defined, PARITY_ODD=0:
  - 8'hEE -> parity bit 0; 8'h0F -> parity bit 0; 8'h07 -> parity bit 1.
  - tx_busy lasts 11*CLKS_PER_BIT cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and helpers for uart_tx and uart_rx
//   uart_state_e  frame FSM states (PARITY only reachable when parity is built in)
//   LINE_IDLE     idle level of the serial line
//   clog2         ceiling log2 for elaboration-time widths
//   clks_per_bit  integer clocks-per-bit divider
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  localparam logic LINE_IDLE = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: loadable down-counter giving a one-cycle tick at the end of each bit period
//   clk, rst     clock, asynchronous active-high reset
//   restart_i    hold/reload the counter with load_i (no tick while high)
//   load_i       reload value (period-1, or half period for mid-bit sampling)
//   tick_o       one-cycle pulse when the counter expires
module uart_baud_tick #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             tick_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = !restart_i && cnt_q == '0;
    cnt_d  = (restart_i || tick_o) ? load_i : cnt_q - 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start/busy handshake, LSB-first start/data/[parity]/stop framing
//   PCLK, PRESET  clock, asynchronous active-high reset
//   tx_data       word to send, captured when tx_start is accepted
//   tx_start      send request, accepted only while idle
//   tx_serial     registered serial line, idle high
//   tx_busy       high for the whole frame
//   tx_done       one-cycle pulse as the frame ends
//   Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd parity).
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = clog2(CPB) > 0 ? clog2(CPB) : 1;
  localparam int IDX_W = clog2(DATA_BITS);
  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 serial_q, serial_d, busy_q, busy_d, done_q, done_d;
  logic                 armed_q, accept, tick, last;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif
  // Counter is held reloaded while idle so the start bit gets a full period.
  uart_baud_tick #(.CNT_W(CNT_W)) u_tick (
    .clk      (PCLK),
    .rst      (PRESET),
    .restart_i(state_q == IDLE),
    .load_i   (CNT_W'(CPB - 1)),
    .tick_o   (tick)
  );
  // armed_q blocks a request on the first edge after reset release.
  assign accept = armed_q && tx_start && state_q == IDLE;
  assign last   = idx_q == IDX_W'(DATA_BITS - 1);
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? START : IDLE;
      START:   state_d = tick ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA:    state_d = (tick && last) ? PARITY : DATA;
      PARITY:  state_d = tick ? STOP : PARITY;
`else
      DATA:    state_d = (tick && last) ? STOP : DATA;
`endif
      STOP:    state_d = (tick && idx_q == IDX_W'(STOP_BITS - 1)) ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // idx_q counts data bits in DATA and stop bits in STOP; cleared on every state change.
  always_comb begin
    sh_d   = accept ? tx_data : (state_q == DATA && tick) ? sh_q >> 1 : sh_q;
    idx_d  = (state_d != state_q) ? '0 : (tick && (state_q == DATA || state_q == STOP)) ? idx_q + 1'b1 : idx_q;
`ifdef UART_TX_PARITY_EN
    par_d  = accept ? (^tx_data) ^ PARITY_ODD : par_q;
    serial_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d : LINE_IDLE;
`else
    serial_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : LINE_IDLE;
`endif
    busy_d = state_d != IDLE;
    done_d = state_q == STOP && state_d == IDLE;
  end
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      sh_q     <= '0;
      idx_q    <= '0;
      serial_q <= LINE_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      armed_q  <= 1'b1;
    end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) par_q <= 1'b0;
    else par_q <= par_d;
`endif
  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed table-driven bench for uart_tx at 10 clocks per bit
module tb_uart_tx;
  localparam int N  = 10;
  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = (1 + DB + PB + 1) * N;
  logic       clk = 1'b0, rst = 1'b1, tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_serial, tx_busy, tx_done;
  int         total = 0, bad = 0;
  always #5 clk = ~clk;
  uart_tx #(.BAUD_RATE(10), .CLK_FREQ(100), .DATA_BITS(DB), .STOP_BITS(1)) dut (
    .PCLK(clk), .PRESET(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done)
  );
  typedef struct { logic [7:0] d; logic [9:0] fr; logic par; } vec_t;
  vec_t vt[8];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  function automatic logic [11:0] frame(input vec_t v);
    return PB ? {1'b1, 1'b1, v.par, v.fr[8:0]} : {2'b11, v.fr};
  endfunction
  task automatic send_frame(input vec_t v, input bit poke);
    int busy_n, done_n, glitch;
    logic [11:0] fr;
    fr = frame(v);
    busy_n = 0; done_n = 0; glitch = 0;
    @(negedge clk); tx_data = v.d; tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0; tx_data = ~v.d;
    for (int c = 0; c <= FL + 1; c++) begin
      @(negedge clk);
      if (poke && c == FL / 2) begin tx_data = 8'hAA; tx_start = 1'b1; end
      if (poke && c == FL / 2 + 1) tx_start = 1'b0;
      busy_n += int'(tx_busy);
      done_n += int'(tx_done);
      if (c < FL) begin
        if (tx_serial !== fr[c / N]) glitch++;
        if (c % N == N / 2) check($sformatf("bit%0d_of_%02h", c / N, v.d), tx_serial, fr[c / N]);
      end else if (tx_serial !== 1'b1) glitch++;
      if (c == FL) begin
        check($sformatf("done_end_%02h", v.d), tx_done, 1);
        check($sformatf("busy_end_%02h", v.d), tx_busy, 0);
      end
    end
    check($sformatf("line_glitch_%02h", v.d), glitch, 0);
    check($sformatf("busy_len_%02h", v.d), busy_n, FL);
    check($sformatf("done_cnt_%02h", v.d), done_n, 1);
    if (poke) begin
      busy_n = 0;
      repeat (3 * N) begin @(negedge clk); busy_n += int'(tx_busy); end
      check("no_second_frame", busy_n, 0);
    end
  endtask
  task automatic chain3();
    int glitch, done_n, busy_n, k, p;
    logic [7:0] w;
    logic [11:0] fr;
    logic e;
    glitch = 0; done_n = 0; busy_n = 0; w = '0;
    @(negedge clk); tx_data = vt[0].d; tx_start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 3 * (FL + 1) + N; c++) begin
      k = c / (FL + 1);
      p = c % (FL + 1);
      @(negedge clk);
      if (k < 2 && p == N) tx_data = vt[k + 1].d;
      if (k == 2 && p == N) tx_start = 1'b0;
      fr = k < 3 ? frame(vt[k]) : '1;
      e = (k >= 3 || p == FL) ? 1'b1 : fr[p / N];
      if (tx_serial !== e) glitch++;
      busy_n += int'(tx_busy);
      done_n += int'(tx_done);
      if (k < 3 && p >= N && p < (DB + 1) * N && p % N == N / 2) w[p / N - 1] = tx_serial;
      if (k < 3 && p == FL) begin
        check($sformatf("rx_word%0d", k), w, vt[k].d);
        check($sformatf("gap_busy%0d", k), tx_busy, 0);
      end
      if (k > 0 && k < 3 && p == 0) check($sformatf("gap_start%0d", k), tx_serial, 0);
    end
    check("chain_glitch", glitch, 0);
    check("chain_done", done_n, 3);
    check("chain_busy", busy_n, 3 * FL);
  endtask
  initial begin
    int chg;
    logic [2:0] prev;
    vt[0] = '{8'h0F, 10'h21E, 1'b0};
    vt[1] = '{8'hEE, 10'h3DC, 1'b0};
    vt[2] = '{8'hCD, 10'h39A, 1'b1};
    vt[3] = '{8'h55, 10'h2AA, 1'b0};
    vt[4] = '{8'h00, 10'h200, 1'b0};
    vt[5] = '{8'hFF, 10'h3FE, 1'b0};
    vt[6] = '{8'h07, 10'h20E, 1'b1};
    vt[7] = '{8'h80, 10'h300, 1'b1};
    #103;
    check("rst_serial", tx_serial, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    @(negedge clk); rst = 1'b0; tx_start = 1'b1; tx_data = 8'h0F;
    @(posedge clk); #1 tx_start = 1'b0;
    chg = 0;
    prev = {tx_serial, tx_busy, tx_done};
    repeat (20 * N) begin
      @(negedge clk);
      if ({tx_serial, tx_busy, tx_done} !== prev) chg++;
      prev = {tx_serial, tx_busy, tx_done};
    end
    check("idle_after_reset", chg, 0);
    check("idle_busy", tx_busy, 0);
    for (int i = 0; i < 8; i++) send_frame(vt[i], 1'b0);
    send_frame(vt[3], 1'b1);
    @(negedge clk); tx_data = 8'hCD; tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    repeat (4 * N + N / 2 + 1) @(negedge clk);
    check("mid_busy", tx_busy, 1);
    rst = 1'b1;
    #1;
    check("async_serial", tx_serial, 1);
    check("async_busy", tx_busy, 0);
    check("async_done", tx_done, 0);
    @(negedge clk); rst = 1'b0;
    send_frame(vt[2], 1'b0);
    chain3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
